// File: rtl/pp_pipeline_accel_fifo_param.sv
// pp_pipeline_accel_fifo_param: show-ahead shift-register FIFO with registered status flags.
// Define PP_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with a clear input.
module pp_pipeline_accel_fifo_param #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 7,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef PP_FIFO_ERR_FLAGS_EN
  input  logic                  if_err_clr,
  output logic                  if_overflow,
  output logic                  if_underflow,
`endif
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  output logic                  if_almost_full,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  if_almost_empty,
  output logic [CNT_WIDTH-1:0]  if_num_data_valid,
  output logic [CNT_WIDTH-1:0]  if_fifo_cap
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF = CNT_WIDTH'(AFULL_THRESH);
  localparam logic [CNT_WIDTH-1:0] AE = CNT_WIDTH'(AEMPTY_THRESH);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_WIDTH-1:0] cnt_q = '0;
  logic [CNT_WIDTH-1:0] cnt_d, rd_idx;
  logic full_n_q = 1'b1, empty_n_q = 1'b0, afull_q = (AFULL_THRESH == 0), aempty_q = 1'b1;
  logic wr_acc, rd_acc;
  always_comb begin
    wr_acc = if_write & if_write_ce & full_n_q;
    rd_acc = if_read & if_read_ce & empty_n_q;
    cnt_d  = reset ? '0 :
             (wr_acc & ~rd_acc) ? cnt_q + ONE :
             (rd_acc & ~wr_acc) ? cnt_q - ONE : cnt_q;
    rd_idx = cnt_q - ONE;
  end
  // Flags are derived from the next count so they change on the same edge as it.
  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    full_n_q  <= cnt_d != CAP;
    empty_n_q <= cnt_d != '0;
    afull_q   <= cnt_d >= AF;
    aempty_q  <= cnt_d <= AE;
  end
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end
  assign if_dout           = mem_q[rd_idx[AW-1:0]];
  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_almost_full    = afull_q;
  assign if_almost_empty   = aempty_q;
  assign if_num_data_valid = cnt_q;
  assign if_fifo_cap       = CAP;
`ifdef PP_FIFO_ERR_FLAGS_EN
  logic ovf_q = 1'b0, unf_q = 1'b0;
  // A new error event takes precedence over a clear in the same cycle.
  always_ff @(posedge clk) begin
    ovf_q <= reset ? 1'b0 : (if_write & if_write_ce & ~full_n_q) ? 1'b1 : if_err_clr ? 1'b0 : ovf_q;
    unf_q <= reset ? 1'b0 : (if_read & if_read_ce & ~empty_n_q) ? 1'b1 : if_err_clr ? 1'b0 : unf_q;
  end
  assign if_overflow  = ovf_q;
  assign if_underflow = unf_q;
`endif
endmodule

// File: tb/tb_pp_pipeline_accel_fifo_param.sv
// tb_pp_pipeline_accel_fifo_param: table vectors, corner sequences and random traffic against a queue model.
module tb_pp_pipeline_accel_fifo_param;
  localparam int DW = 64;
  localparam int D = 7;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] if_din = '0;
  logic if_write = 1'b0, if_write_ce = 1'b0, if_read = 1'b0, if_read_ce = 1'b0;
  logic if_full_n, if_almost_full, if_empty_n, if_almost_empty;
  logic [DW-1:0] if_dout;
  logic [2:0] if_num_data_valid, if_fifo_cap;
`ifdef PP_FIFO_ERR_FLAGS_EN
  logic if_err_clr = 1'b0;
  logic if_overflow, if_underflow;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] q[$];
  logic ovf_m = 1'b0, unf_m = 1'b0;

  typedef struct {
    logic w, r;
    logic [DW-1:0] din;
    int cnt;
    logic empty_n, full_n, af, ae;
    logic [DW-1:0] dout;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  pp_pipeline_accel_fifo_param dut (
    .clk(clk), .reset(reset),
`ifdef PP_FIFO_ERR_FLAGS_EN
    .if_err_clr(if_err_clr), .if_overflow(if_overflow), .if_underflow(if_underflow),
`endif
    .if_din(if_din), .if_write(if_write), .if_write_ce(if_write_ce),
    .if_full_n(if_full_n), .if_almost_full(if_almost_full),
    .if_read(if_read), .if_read_ce(if_read_ce), .if_dout(if_dout),
    .if_empty_n(if_empty_n), .if_almost_empty(if_almost_empty),
    .if_num_data_valid(if_num_data_valid), .if_fifo_cap(if_fifo_cap)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    chk("num_data_valid", DW'(if_num_data_valid), DW'(n));
    chk("empty_n", DW'(if_empty_n), DW'(n != 0));
    chk("full_n", DW'(if_full_n), DW'(n != D));
    chk("almost_full", DW'(if_almost_full), DW'(n >= 6));
    chk("almost_empty", DW'(if_almost_empty), DW'(n <= 1));
    chk("fifo_cap", DW'(if_fifo_cap), DW'(D));
    if (n > 0) chk("dout", if_dout, q[0]);
`ifdef PP_FIFO_ERR_FLAGS_EN
    chk("overflow", DW'(if_overflow), DW'(ovf_m));
    chk("underflow", DW'(if_underflow), DW'(unf_m));
`endif
  endtask

  // Drive one cycle's inputs, advance the model by the FIFO rules, then compare.
  task automatic cyc(input logic w, input logic wc, input logic r, input logic rc, input logic [DW-1:0] d);
    logic wreq, rreq, wa, ra, clr;
    if_write = w; if_write_ce = wc; if_read = r; if_read_ce = rc; if_din = d;
    wreq = w & wc;
    rreq = r & rc;
    wa = wreq && q.size() < D;
    ra = rreq && q.size() > 0;
    clr = 1'b0;
`ifdef PP_FIFO_ERR_FLAGS_EN
    clr = if_err_clr;
`endif
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      ovf_m = (wreq && !wa) ? 1'b1 : clr ? 1'b0 : ovf_m;
      unf_m = (rreq && !ra) ? 1'b1 : clr ? 1'b0 : unf_m;
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
    end
    check_state();
  endtask

  initial begin
    for (int k = 1; k <= 7; k++) begin
      tbl[k-1] = '{w: 1'b1, r: 1'b0, din: DW'(k), cnt: k, empty_n: 1'b1,
                   full_n: (k != 7), af: (k >= 6), ae: (k <= 1), dout: DW'(1)};
      tbl[k+6] = '{w: 1'b0, r: 1'b1, din: '0, cnt: 7 - k, empty_n: (k != 7),
                   full_n: 1'b1, af: (7 - k >= 6), ae: (7 - k <= 1), dout: DW'(k + 1)};
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset num_data_valid", DW'(if_num_data_valid), '0);
    chk("reset empty_n", DW'(if_empty_n), '0);
    chk("reset full_n", DW'(if_full_n), DW'(1));
    chk("reset almost_empty", DW'(if_almost_empty), DW'(1));
    chk("reset almost_full", DW'(if_almost_full), '0);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].w, 1'b1, tbl[i].r, 1'b1, tbl[i].din);
      chk($sformatf("vec%0d cnt", i), DW'(if_num_data_valid), DW'(tbl[i].cnt));
      chk($sformatf("vec%0d empty_n", i), DW'(if_empty_n), DW'(tbl[i].empty_n));
      chk($sformatf("vec%0d full_n", i), DW'(if_full_n), DW'(tbl[i].full_n));
      chk($sformatf("vec%0d af", i), DW'(if_almost_full), DW'(tbl[i].af));
      chk($sformatf("vec%0d ae", i), DW'(if_almost_empty), DW'(tbl[i].ae));
      if (tbl[i].cnt > 0) chk($sformatf("vec%0d dout", i), if_dout, tbl[i].dout);
    end
    // Simultaneous read/write at count 3 keeps the count and the order.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1, {$urandom, $urandom});
      chk("rw@3 cnt", DW'(if_num_data_valid), DW'(3));
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
    cyc(1'b1, 1'b1, 1'b1, 1'b1, {$urandom, $urandom});
    chk("rw@full cnt", DW'(if_num_data_valid), DW'(6));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 64'hABCD);
    chk("rw@empty cnt", DW'(if_num_data_valid), DW'(1));
    chk("rw@empty dout", if_dout, 64'hABCD);
    // Reset wins over a write at count 5.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
    chk("pre-reset cnt", DW'(if_num_data_valid), DW'(5));
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h55);
    chk("reset@5 cnt", DW'(if_num_data_valid), '0);
    chk("reset@5 empty_n", DW'(if_empty_n), '0);
    chk("reset@5 full_n", DW'(if_full_n), DW'(1));
    reset = 1'b0;
`ifdef PP_FIFO_ERR_FLAGS_EN
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h99);
    chk("ovf set", DW'(if_overflow), DW'(1));
    chk("ovf cnt", DW'(if_num_data_valid), DW'(7));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("ovf held", DW'(if_overflow), DW'(1));
    if_err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    if_err_clr = 1'b0;
    chk("ovf clr", DW'(if_overflow), '0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    chk("unf set", DW'(if_underflow), DW'(1));
    chk("unf cnt", DW'(if_num_data_valid), '0);
    if_err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    chk("unf set beats clr", DW'(if_underflow), DW'(1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    if_err_clr = 1'b0;
    chk("unf clr", DW'(if_underflow), '0);
`endif
    for (int i = 0; i < 500; i++) begin
`ifdef PP_FIFO_ERR_FLAGS_EN
      if_err_clr = ($urandom_range(0, 7) == 0);
`endif
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), {$urandom, $urandom});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
